vector_operand_select_buf: RTL and testbench

- Parametrised successor to the ID-stage vector/scalar data select.
- Each lane selects between vector register-file data and alternate operand sources, under a 2-bit mode carried with each beat.
- The selected operand vector is registered into a 2-entry skid buffer with valid/ready handshakes on both sides, decoupling ID from EX.
- Full throughput (one beat per cycle), stall-tolerant, flushable.

---
 rtl/vector_operand_select_buf.sv | 113 +++++++++++
 tb/tb_vector_operand_select_buf.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_operand_select_buf.sv
// Per-lane operand select feeding a 2-entry skid buffer between ID and EX.
// Define VECTOR_OPERAND_SELECT_PARITY_EN to add per-lane even parity (out_parity) stored with each entry.
module vector_operand_select_buf #(
  parameter int LANES = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               mode,
  input  logic [LANES-1:0]         lane_mask,
  input  logic [LANES*WIDTH-1:0]   vin,
  input  logic [LANES*WIDTH-1:0]   ain,
  input  logic [WIDTH-1:0]         scalar,
  output logic                     out_valid,
  input  logic                     out_ready,
`ifdef VECTOR_OPERAND_SELECT_PARITY_EN
  output logic [LANES-1:0]         out_parity,
`endif
  output logic [LANES*WIDTH-1:0]   out_data
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]             state;
  logic [LANES*WIDTH-1:0] sel;
  logic [LANES*WIDTH-1:0] head;
  logic [LANES*WIDTH-1:0] tail;
  logic                   accept;
  logic                   pop;
  logic                   head_from_sel;
  logic                   head_from_tail;
  logic                   tail_from_sel;

  always_comb begin
    sel = '0;
    for (int i = 0; i < LANES; i++) begin
      case (mode)
        2'b00:   sel[i*WIDTH +: WIDTH] = vin[i*WIDTH +: WIDTH];
        2'b01:   sel[i*WIDTH +: WIDTH] = ain[i*WIDTH +: WIDTH];
        2'b10:   sel[i*WIDTH +: WIDTH] = scalar;
        default: sel[i*WIDTH +: WIDTH] = lane_mask[i] ? ain[i*WIDTH +: WIDTH]
                                                      : vin[i*WIDTH +: WIDTH];
      endcase
    end
  end

  // in_ready comes from the state register alone, so out_ready never reaches the upstream side.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = head;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign head_from_sel  = accept & ((state == EMPTY) | ((state == ONE) & pop));
  assign tail_from_sel  = accept & (state == ONE) & ~pop;
  assign head_from_tail = pop & (state == TWO);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY:   if (accept) state <= ONE;
        ONE:     if (accept && !pop) state <= TWO;
                 else if (!accept && pop) state <= EMPTY;
        TWO:     if (pop) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (head_from_sel)       head <= sel;
      else if (head_from_tail) head <= tail;
      if (tail_from_sel)       tail <= sel;
    end
  end

`ifdef VECTOR_OPERAND_SELECT_PARITY_EN
  logic [LANES-1:0] sel_par;
  logic [LANES-1:0] head_par;
  logic [LANES-1:0] tail_par;

  always_comb begin
    sel_par = '0;
    for (int i = 0; i < LANES; i++) sel_par[i] = ^sel[i*WIDTH +: WIDTH];
  end

  // Parity is captured at write time and follows its data through the buffer.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head_par <= '0;
      tail_par <= '0;
    end else begin
      if (head_from_sel)       head_par <= sel_par;
      else if (head_from_tail) head_par <= tail_par;
      if (tail_from_sel)       tail_par <= sel_par;
    end
  end

  assign out_parity = head_par;
`endif

endmodule

// File: tb/tb_vector_operand_select_buf.sv
// Self-checking bench for vector_operand_select_buf: mode table, backpressure, throughput, flush, random traffic.
// Parity checks are compiled in when VECTOR_OPERAND_SELECT_PARITY_EN is defined.
module tb_vector_operand_select_buf;
  localparam int L  = 8;
  localparam int W  = 32;
  localparam int VW = L * W;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    mode;
  logic [L-1:0]  lane_mask;
  logic [VW-1:0] vin;
  logic [VW-1:0] ain;
  logic [W-1:0]  scalar;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_data;
`ifdef VECTOR_OPERAND_SELECT_PARITY_EN
  logic [L-1:0]  out_parity;
`endif

  vector_operand_select_buf #(.LANES(L), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .lane_mask (lane_mask),
    .vin       (vin),
    .ain       (ain),
    .scalar    (scalar),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef VECTOR_OPERAND_SELECT_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    mode;
    logic [VW-1:0] exp;
  } vec_t;

  vec_t          tbl[4];
  logic [VW-1:0] sb[$];
  logic [VW-1:0] cur_exp;
  logic [VW-1:0] beat_a;
  int            checks = 0;
  int            passes = 0;
  int            pop_count = 0;

  function automatic logic [VW-1:0] model_sel(input logic [1:0] m, input logic [L-1:0] mk,
                                              input logic [VW-1:0] v, input logic [VW-1:0] a,
                                              input logic [W-1:0] s);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < L; i++) begin
      if (m == 2'b00)      r[i*W +: W] = v[i*W +: W];
      else if (m == 2'b01) r[i*W +: W] = a[i*W +: W];
      else if (m == 2'b10) r[i*W +: W] = s;
      else                 r[i*W +: W] = mk[i] ? a[i*W +: W] : v[i*W +: W];
    end
    return r;
  endfunction

  function automatic logic [L-1:0] model_par(input logic [VW-1:0] d);
    logic [L-1:0] p;
    for (int i = 0; i < L; i++) p[i] = ^d[i*W +: W];
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock: observe mid-cycle, score pops and pushes, return 1 time unit after the next rising edge.
  task automatic cycle();
    logic [VW-1:0] e;
    @(negedge clk);
    if (out_valid === 1'b1 && out_ready) begin
      pop_count++;
      if (sb.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_out: got %h expected no beat", out_data);
      end else begin
        e = sb.pop_front();
        checkOutput("out_data", out_data, e);
`ifdef VECTOR_OPERAND_SELECT_PARITY_EN
        checkOutput("out_parity", VW'(out_parity), VW'(model_par(e)));
`endif
      end
    end
    if (!rst_n || flush) sb.delete();
    else if (in_valid && in_ready === 1'b1) sb.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] m);
    in_valid = v;
    mode     = m;
    cur_exp  = model_sel(m, lane_mask, vin, ain, scalar);
  endtask

  task automatic randomData();
    for (int i = 0; i < L; i++) begin
      vin[i*W +: W] = $urandom;
      ain[i*W +: W] = $urandom;
    end
    scalar    = $urandom;
    lane_mask = L'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    mode = 2'b00; lane_mask = 8'b1010_0101; scalar = 32'hDEAD_BEEF;
    for (int i = 0; i < L; i++) begin
      vin[i*W +: W] = 32'h1000_0000 + i;
      ain[i*W +: W] = 32'hA000_0000 + i;
    end
    cur_exp = '0;

    // Table of expected sweep results, written lane by lane from the mode rules.
    for (int k = 0; k < 4; k++) tbl[k].mode = 2'(k);
    for (int i = 0; i < L; i++) begin
      tbl[0].exp[i*W +: W] = 32'h1000_0000 + i;
      tbl[1].exp[i*W +: W] = 32'hA000_0000 + i;
      tbl[2].exp[i*W +: W] = 32'hDEAD_BEEF;
      tbl[3].exp[i*W +: W] = (i == 0 || i == 2 || i == 5 || i == 7) ? 32'hA000_0000 + i
                                                                   : 32'h1000_0000 + i;
    end

    // Reset held for two cycles with a beat presented.
    cycle();
    cycle();
    rst_n = 1'b1; in_valid = 1'b0;
    checkOutput("rst_out_valid", VW'(out_valid), '0);
    checkOutput("rst_out_data", out_data, '0);
    checkOutput("rst_in_ready", VW'(in_ready), VW'(1));
    cycle();
    checkOutput("rst_nothing_emitted", VW'(pop_count), '0);

    // Mode sweep back-to-back, each result visible one cycle after acceptance.
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      mode     = tbl[k].mode;
      cur_exp  = tbl[k].exp;
      cycle();
      checkOutput("sweep_valid", VW'(out_valid), VW'(1));
      checkOutput("sweep_data", out_data, tbl[k].exp);
    end
    in_valid = 1'b0;
    cycle();
    checkOutput("sweep_drain", VW'(sb.size()), '0);

    // Backpressure: A and B fill the buffer, C waits until space frees.
    out_ready = 1'b0;
    randomData();
    applyStimulus(1'b1, 2'b01);
    beat_a = cur_exp;
    checkOutput("bp_ready_empty", VW'(in_ready), VW'(1));
    cycle();
    checkOutput("bp_ready_one", VW'(in_ready), VW'(1));
    randomData();
    applyStimulus(1'b1, 2'b11);
    cycle();
    checkOutput("bp_ready_two", VW'(in_ready), '0);
    checkOutput("bp_head_a", out_data, beat_a);
    randomData();
    applyStimulus(1'b1, 2'b10);
    cycle();
    cycle();
    checkOutput("bp_hold_ready", VW'(in_ready), '0);
    checkOutput("bp_hold_data", out_data, beat_a);
    out_ready = 1'b1;
    cycle();
    checkOutput("bp_ready_after_pop", VW'(in_ready), VW'(1));
    cycle();
    in_valid = 1'b0;
    cycle();
    checkOutput("bp_drain", VW'(sb.size()), '0);
    checkOutput("bp_empty", VW'(out_valid), '0);

    // Throughput: 16 beats, one per cycle.
    pop_count = 0;
    for (int k = 0; k < 16; k++) begin
      randomData();
      applyStimulus(1'b1, 2'($urandom));
      checkOutput("tp_in_ready", VW'(in_ready), VW'(1));
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    checkOutput("tp_pops", VW'(pop_count), VW'(16));
    checkOutput("tp_drain", VW'(sb.size()), '0);

    // Flush while full, with a beat presented in the flush cycle.
    out_ready = 1'b0;
    randomData(); applyStimulus(1'b1, 2'b00); cycle();
    randomData(); applyStimulus(1'b1, 2'b01); cycle();
    checkOutput("fl_full", VW'(in_ready), '0);
    randomData(); applyStimulus(1'b1, 2'b10);
    flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("fl_out_valid", VW'(out_valid), '0);
    checkOutput("fl_in_ready", VW'(in_ready), VW'(1));
    checkOutput("fl_out_data", out_data, '0);
    // Flush in ONE with an acceptable beat: the beat must not be stored.
    randomData(); applyStimulus(1'b1, 2'b11); cycle();
    randomData(); applyStimulus(1'b1, 2'b01);
    flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("fl_one_valid", VW'(out_valid), '0);
    out_ready = 1'b1;
    pop_count = 0;
    for (int k = 0; k < 3; k++) cycle();
    checkOutput("fl_nothing_emitted", VW'(pop_count), '0);

`ifdef VECTOR_OPERAND_SELECT_PARITY_EN
    scalar = 32'h0000_0001;
    applyStimulus(1'b1, 2'b10);
    cycle();
    checkOutput("par_odd", VW'(out_parity), VW'(8'hFF));
    scalar = 32'h0000_0003;
    applyStimulus(1'b1, 2'b10);
    cycle();
    checkOutput("par_even", VW'(out_parity), '0);
    in_valid = 1'b0;
    cycle();
`endif

    // Random traffic with stalls, then a bounded drain.
    for (int k = 0; k < 300; k++) begin
      randomData();
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom));
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid === 1'b1 && in_ready === 1'b1 && sb.size() > 1) begin
        checks++;
        $display("[TB] FAIL rand_occupancy: got in_ready 1 expected 0 with %0d queued", sb.size());
      end
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 10 && sb.size() != 0; k++) cycle();
    checkOutput("rand_drain", VW'(sb.size()), '0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
